// File: rtl/chrono_pkg.sv
// Shared types and constants for the BCD chronometer (HH:MM:SS.cc, 8 nibbles).
package chrono_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } chrono_state_e;

  typedef struct packed {
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] seg1;
    logic [3:0] seg0;
    logic [3:0] cseg1;
    logic [3:0] cseg0;
  } bcd_time_t;

  localparam logic [3:0] DIGIT_MAX9 = 4'd9;
  localparam logic [3:0] DIGIT_MAX5 = 4'd5;
  localparam bcd_time_t  BCD_ZERO   = '0;

  function automatic logic preset_ok(input bcd_time_t t, input int hour_max);
    logic ok;
    ok = (t.cseg0 <= DIGIT_MAX9) && (t.cseg1 <= DIGIT_MAX9) &&
         (t.seg0  <= DIGIT_MAX9) && (t.seg1  <= DIGIT_MAX5) &&
         (t.min0  <= DIGIT_MAX9) && (t.min1  <= DIGIT_MAX5) &&
         (t.hour0 <= DIGIT_MAX9) && (t.hour1 <= DIGIT_MAX9);
    ok = ok && ((int'(t.hour1) * 10 + int'(t.hour0)) <= hour_max);
    return ok;
  endfunction

endpackage

// File: rtl/chrono_bcd_digit.sv
// One BCD digit of modulus MAX+1: clear > load > count; value visible one cycle after en.
// No backpressure; terminal flags the digit that passes carry (up) or borrow (down).
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] q,
  output logic       terminal
);
  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      if (!dir) q_d = (q_q >= MAX) ? 4'd0 : q_q + 4'd1;
      else      q_d = (q_q == 4'd0) ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q        = q_q;
  assign terminal = dir ? (q_q == 4'd0) : (q_q >= MAX);
endmodule

// File: rtl/chrono_counter.sv
// BCD chronometer with run/pause/done control; all outputs registered, time moves the cycle after tick_i.
// No backpressure. Optional lap register enabled by defining CHRONO_LAP_EN.
module chrono_counter
  import chrono_pkg::*;
#(
  parameter int HOUR_MAX     = 99,
  parameter bit PRESET_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        dir_i,
  input  logic        load_i,
  input  logic [31:0] preset_i,
  input  logic        lap_i,
  output logic [31:0] time_o,
  output logic [31:0] lap_o,
  output logic        lap_valid_o,
  output logic [1:0]  state_o,
  output logic        done_o,
  output logic        wrap_o,
  output logic        err_o
);
  localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  chrono_state_e state_q, state_d;
  logic dir_q, dir_d, done_q, done_d, wrap_q, wrap_d, err_q, err_d;
  logic cmd_ld, cmd_stop, cmd_start, run, is_zero, ld_acc, cnt, hr_ovr;
  logic [3:0] dig_q [8];
  logic [3:0] dig_ld_val [8];
  logic [7:0] dig_term, dig_en, dig_ld, hours;
  bcd_time_t  cur;

  assign cur   = {dig_q[7], dig_q[6], dig_q[5], dig_q[4], dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
  assign hours = {dig_q[7], dig_q[6]};

  for (genvar g = 0; g < 8; g++) begin : g_dig
    bcd_digit #(.MAX((g == 3 || g == 5) ? DIGIT_MAX5 : DIGIT_MAX9)) u_dig (
      .clk(clk), .rst(rst), .clr(clear_i), .ld(dig_ld[g]), .ld_val(dig_ld_val[g]),
      .en(dig_en[g]), .dir(dir_q), .q(dig_q[g]), .terminal(dig_term[g])
    );
  end

  always_comb begin
    cmd_ld    = load_i & ~clear_i;
    cmd_stop  = stop_i & ~clear_i & ~load_i;
    cmd_start = start_i & ~clear_i & ~load_i & ~stop_i;
    run       = (state_q == RUN);
    is_zero   = (cur == BCD_ZERO);
    ld_acc    = cmd_ld & ~run & (~PRESET_CHECK | preset_ok(bcd_time_t'(preset_i), HOUR_MAX));
    err_d     = cmd_ld & ~run & ~ld_acc;
    cnt       = run & tick_i & ~clear_i;

    dig_en[0] = cnt;
    for (int i = 1; i < 8; i++) dig_en[i] = dig_en[i-1] & dig_term[i-1];
    dig_ld = {8{ld_acc}};
    for (int i = 0; i < 8; i++) dig_ld_val[i] = preset_i[4*i +: 4];

    // Hours roll at HOUR_MAX (or 99 after an unchecked preset) rather than via the digit chain.
    hr_ovr = dig_en[6] & (dir_q ? (hours == 8'h00)
                                : (hours == HOUR_MAX_BCD || hours == 8'h99));
    if (hr_ovr) begin
      dig_en[7:6] = 2'b00;
      dig_ld[7:6] = 2'b11;
      {dig_ld_val[7], dig_ld_val[6]} = dir_q ? HOUR_MAX_BCD : 8'h00;
    end
    wrap_d = hr_ovr & ~dir_q;
    done_d = cnt & dir_q & (cur == bcd_time_t'(32'h0000_0001));

    state_d = state_q;
    dir_d   = dir_q;
    if (clear_i || ld_acc) begin
      state_d = IDLE;
    end else if (cmd_stop && run) begin
      state_d = PAUSE;
    end else if (cmd_start && !run && !(dir_i && is_zero)) begin
      state_d = RUN;
      dir_d   = dir_i;
    end
    if (done_d) state_d = DONE;
  end

`ifdef CHRONO_LAP_EN
  bcd_time_t lap_q, lap_d;
  logic      lap_vld_q, lap_vld_d;

  always_comb begin
    lap_d     = lap_q;
    lap_vld_d = lap_vld_q;
    if (clear_i) begin
      lap_d     = BCD_ZERO;
      lap_vld_d = 1'b0;
    end else if (lap_i && !load_i && !stop_i && !start_i && run) begin
      lap_d     = cur;
      lap_vld_d = 1'b1;
    end
  end

  assign lap_o       = lap_q;
  assign lap_valid_o = lap_vld_q;
`else
  logic unused_lap;
  assign unused_lap  = lap_i;
  assign lap_o       = '0;
  assign lap_valid_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CHRONO_LAP_EN
      lap_q     <= BCD_ZERO;
      lap_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
`ifdef CHRONO_LAP_EN
      lap_q     <= lap_d;
      lap_vld_q <= lap_vld_d;
`endif
    end
  end

  assign time_o  = cur;
  assign state_o = state_q;
  assign done_o  = done_q;
  assign wrap_o  = wrap_q;
  assign err_o   = err_q;
endmodule
